// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length Huffman codes MSB-first into a byte stream.
// Codes are acknowledged with a one-cycle load pulse; flush pads the final byte.
module huffman_bit_packer #(
   parameter logic PAD_BIT = 1'b0,
   parameter int   COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         code_in,
   input  logic [3:0]         code_len,
   input  logic               code_valid,
   output logic               load,
   output logic [7:0]         byte_out,
   output logic               byte_valid,
   input  logic               byte_ready,
   input  logic               flush,
   output logic               flush_done,
   output logic [4:0]         bit_cnt,
   output logic [COUNT_W-1:0] byte_count
);

   typedef enum logic [1:0] {IDLE, ACK, FLUSH} state_t;

   state_t      state;
   logic [16:0] acc;
   logic        flush_req;

   logic        handshake, is_free, emit, flush_pend, capture;
   logic [3:0]  len_c;
   logic [10:0] mask;
   logic [16:0] code_m, acc_s, acc_cap, pad_fill;
   logic [4:0]  cnt_s, cnt_cap, shamt;

   always_comb begin
      handshake  = byte_valid && byte_ready;
      is_free    = !byte_valid || handshake;
      emit       = is_free && (bit_cnt >= 5'd8);
      flush_pend = flush_req || flush;
      capture    = (state == IDLE) && code_valid && (bit_cnt <= 5'd7) && !flush_pend;
      len_c      = (code_len > 4'd10) ? 4'd10 : code_len;
      mask       = (11'd1 << len_c) - 11'd1;
      code_m     = {7'd0, code_in & mask[9:0]};
      // Emission shifts first so a same-cycle append lands after the departing byte.
      acc_s      = emit ? (acc << 8) : acc;
      cnt_s      = emit ? (bit_cnt - 5'd8) : bit_cnt;
      shamt      = 5'd17 - cnt_s - {1'b0, len_c};
      acc_cap    = acc_s | (code_m << shamt);
      cnt_cap    = cnt_s + {1'b0, len_c};
      pad_fill   = 17'h1FE00 & (17'h1FFFF >> bit_cnt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         acc        <= '0;
         bit_cnt    <= '0;
         flush_req  <= 1'b0;
         load       <= 1'b0;
         flush_done <= 1'b0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         byte_count <= '0;
      end else begin
         load       <= 1'b0;
         flush_done <= 1'b0;
         acc        <= acc_s;
         bit_cnt    <= cnt_s;
         if (flush) flush_req <= 1'b1;
         if (handshake) byte_count <= byte_count + COUNT_W'(1);
         if (emit) begin
            byte_out   <= acc[16:9];
            byte_valid <= 1'b1;
         end else if (handshake) begin
            byte_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (capture) begin
                  acc     <= acc_cap;
                  bit_cnt <= cnt_cap;
                  load    <= 1'b1;
                  state   <= ACK;
               end else if (flush_pend) begin
                  state <= FLUSH;
               end
            end
            // Producer keeps code_valid up for a while after load; wait it out.
            ACK: if (!code_valid) state <= IDLE;
            FLUSH: begin
               if (bit_cnt == 5'd0 && !byte_valid) begin
                  flush_done <= 1'b1;
                  flush_req  <= flush;
                  state      <= IDLE;
               end else if (bit_cnt != 5'd0 && bit_cnt < 5'd8) begin
                  acc     <= acc | (PAD_BIT ? pad_fill : 17'd0);
                  bit_cnt <= 5'd8;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: a bit-queue reference model scoreboards the byte stream
// of two instances (pad 0 / 16-bit count, pad 1 / 3-bit count) under directed and random traffic.
module tb_huffman_bit_packer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] code_in = '0;
   logic [3:0] code_len = '0;
   logic       code_valid = 1'b0, byte_ready = 1'b0, flush = 1'b0;

   logic        load0, byte_valid0, flush_done0, load1, byte_valid1, flush_done1;
   logic [7:0]  byte_out0, byte_out1;
   logic [4:0]  bit_cnt0, bit_cnt1;
   logic [15:0] byte_count0;
   logic [2:0]  byte_count1;

   always #5 clk = ~clk;

   huffman_bit_packer u0 (
      .clk(clk), .reset(reset), .code_in(code_in), .code_len(code_len), .code_valid(code_valid),
      .load(load0), .byte_out(byte_out0), .byte_valid(byte_valid0), .byte_ready(byte_ready),
      .flush(flush), .flush_done(flush_done0), .bit_cnt(bit_cnt0), .byte_count(byte_count0));

   huffman_bit_packer #(.PAD_BIT(1'b1), .COUNT_W(3)) u1 (
      .clk(clk), .reset(reset), .code_in(code_in), .code_len(code_len), .code_valid(code_valid),
      .load(load1), .byte_out(byte_out1), .byte_valid(byte_valid1), .byte_ready(byte_ready),
      .flush(flush), .flush_done(flush_done1), .bit_cnt(bit_cnt1), .byte_count(byte_count1));

   int tests = 0, fails = 0;
   bit mq0[$], mq1[$];
   logic [7:0] eq0[$], eq1[$], got0[$], got1[$];
   int nbytes = 0, load_cnt = 0, fd_cnt = 0, fd_exp = 0;
   logic [4:0] cnt_at_load;
   bit rnd_on = 1'b0;

   // Reference model: a plain bit queue chopped into bytes.
   task automatic model_pack();
      logic [7:0] b;
      while (mq0.size() >= 8) begin
         for (int i = 0; i < 8; i++) b = {b[6:0], mq0.pop_front()};
         eq0.push_back(b);
         nbytes++;
      end
      while (mq1.size() >= 8) begin
         for (int i = 0; i < 8; i++) b = {b[6:0], mq1.pop_front()};
         eq1.push_back(b);
      end
   endtask

   task automatic model_push(input logic [9:0] c, input logic [3:0] l);
      int n;
      n = (l > 10) ? 10 : int'(l);
      for (int i = n - 1; i >= 0; i--) begin
         mq0.push_back(c[i]);
         mq1.push_back(c[i]);
      end
      model_pack();
   endtask

   task automatic model_flush();
      while (mq0.size() % 8 != 0) mq0.push_back(1'b0);
      while (mq1.size() % 8 != 0) mq1.push_back(1'b1);
      model_pack();
      fd_exp++;
   endtask

   task automatic model_clear();
      mq0.delete(); mq1.delete(); eq0.delete(); eq1.delete(); got0.delete(); got1.delete();
      nbytes = 0; load_cnt = 0; fd_cnt = 0; fd_exp = 0;
   endtask

   // Scoreboard: a byte is handed over at the next rising edge when valid && ready here.
   always @(negedge clk) begin
      if (!reset) begin
         if (byte_valid0 && byte_ready) begin
            tests++;
            if (eq0.size() == 0) begin
               fails++; $display("FAIL sb_byte0: got %h, expected no byte", byte_out0);
            end else if (byte_out0 !== eq0[0]) begin
               fails++; $display("FAIL sb_byte0: got %h expected %h", byte_out0, eq0[0]);
            end
            if (eq0.size() != 0) void'(eq0.pop_front());
            got0.push_back(byte_out0);
         end
         if (byte_valid1 && byte_ready) begin
            tests++;
            if (eq1.size() == 0) begin
               fails++; $display("FAIL sb_byte1: got %h, expected no byte", byte_out1);
            end else if (byte_out1 !== eq1[0]) begin
               fails++; $display("FAIL sb_byte1: got %h expected %h", byte_out1, eq1[0]);
            end
            if (eq1.size() != 0) void'(eq1.pop_front());
            got1.push_back(byte_out1);
         end
         if (load0) load_cnt++;
         if (flush_done0) fd_cnt++;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_code(input logic [9:0] c, input logic [3:0] l, input int hold,
                            input int max_cyc, output bit ok);
      code_in = c; code_len = l; code_valid = 1'b1; ok = 1'b0;
      for (int k = 0; k < max_cyc && !ok; k++) begin
         tick();
         if (load0) ok = 1'b1;
      end
      if (ok) begin
         cnt_at_load = bit_cnt0;
         model_push(c, l);
         tick(hold);
         code_valid = 1'b0;
         tick();
      end
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int k = 0; k < 500 && !done; k++) begin
         tick();
         done = (eq0.size() == 0) && !byte_valid0 && (bit_cnt0 < 5'd8);
      end
      tests++;
      if (!done) begin fails++; $display("FAIL drain_timeout: bit_cnt %0d pending %0d", bit_cnt0, eq0.size()); end
      tick(2);
   endtask

   task automatic wait_flush();
      bit seen = 1'b0;
      for (int k = 0; k < 500 && !seen; k++) begin
         tick();
         seen = flush_done0;
      end
      tests++;
      if (!seen) begin fails++; $display("FAIL flush_timeout: flush_done never pulsed"); end
      tick(2);
   endtask

   task automatic reset_dut();
      code_valid = 1'b0; flush = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(2);
      tests += 7;
      if (load0 !== 1'b0) begin fails++; $display("FAIL rst_load: got %b expected 0", load0); end
      if (byte_valid0 !== 1'b0) begin fails++; $display("FAIL rst_byte_valid: got %b expected 0", byte_valid0); end
      if (byte_out0 !== 8'h00) begin fails++; $display("FAIL rst_byte_out: got %h expected 00", byte_out0); end
      if (flush_done0 !== 1'b0) begin fails++; $display("FAIL rst_flush_done: got %b expected 0", flush_done0); end
      if (bit_cnt0 !== 5'd0) begin fails++; $display("FAIL rst_bit_cnt: got %0d expected 0", bit_cnt0); end
      if (byte_count0 !== 16'd0) begin fails++; $display("FAIL rst_byte_count: got %0d expected 0", byte_count0); end
      if (byte_count1 !== 3'd0) begin fails++; $display("FAIL rst_byte_count1: got %0d expected 0", byte_count1); end
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_two_codes();
      bit ok1, ok2;
      byte_ready = 1'b1;
      send_code(10'h005, 4'd3, 0, 50, ok1);
      send_code(10'h01E, 4'd5, 0, 50, ok2);
      wait_drain();
      tests += 5;
      if (!(ok1 && ok2)) begin fails++; $display("FAIL two_capture: got %b%b expected 11", ok1, ok2); end
      if (load_cnt != 2) begin fails++; $display("FAIL two_loads: got %0d expected 2", load_cnt); end
      if (got0.size() != 1 || got0[0] !== 8'hBE) begin fails++; $display("FAIL two_byte: got %p expected BE", got0); end
      if (bit_cnt0 !== 5'd0) begin fails++; $display("FAIL two_bit_cnt: got %0d expected 0", bit_cnt0); end
      if (byte_count0 !== 16'(nbytes) || nbytes != 1) begin fails++; $display("FAIL two_count: got %0d expected 1", byte_count0); end
   endtask

   task automatic test_hold();
      bit ok;
      int base = load_cnt;
      send_code(10'h003, 4'd2, 3, 50, ok);
      tick(3);
      tests += 2;
      if (!ok || load_cnt - base != 1) begin fails++; $display("FAIL hold_loads: got %0d expected 1", load_cnt - base); end
      if (bit_cnt0 !== 5'(mq0.size())) begin fails++; $display("FAIL hold_bit_cnt: got %0d expected %0d", bit_cnt0, mq0.size()); end
   endtask

   task automatic test_seventeen();
      bit ok;
      reset_dut();
      byte_ready = 1'b1;
      send_code(10'h055, 4'd7, 0, 50, ok);
      tests += 3;
      if (bit_cnt0 !== 5'd7) begin fails++; $display("FAIL b17_pre: got %0d expected 7", bit_cnt0); end
      send_code(10'h3FF, 4'd10, 1, 50, ok);
      if (!ok || cnt_at_load !== 5'd17) begin fails++; $display("FAIL b17_peak: got %0d expected 17", cnt_at_load); end
      wait_drain();
      if (got0.size() != 2 || got0[0] !== 8'hAB || got0[1] !== 8'hFF) begin
         fails++; $display("FAIL b17_bytes: got %p expected AB FF", got0);
      end
      tests++;
      if (bit_cnt0 !== 5'd1) begin fails++; $display("FAIL b17_rem: got %0d expected 1", bit_cnt0); end
   endtask

   task automatic test_backpressure();
      bit ok, all_ok = 1'b1;
      reset_dut();
      byte_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin send_code(10'h00F, 4'd4, 0, 50, ok); all_ok &= ok; end
      send_code(10'h00F, 4'd4, 0, 30, ok);
      tests += 6;
      if (!all_ok) begin fails++; $display("FAIL bp_fill: a capture before the stall timed out"); end
      if (ok) begin fails++; $display("FAIL bp_stall: got capture expected stall"); end
      // 16 bits in: one byte waits in the output register, 8 bits wait in the accumulator.
      if (bit_cnt0 !== 5'd8) begin fails++; $display("FAIL bp_bit_cnt: got %0d expected 8", bit_cnt0); end
      if (byte_valid0 !== 1'b1 || byte_out0 !== 8'hFF) begin fails++; $display("FAIL bp_pending: got %b/%h expected 1/FF", byte_valid0, byte_out0); end
      if (load0 !== 1'b0) begin fails++; $display("FAIL bp_load: got %b expected 0", load0); end
      byte_ready = 1'b1;
      send_code(10'h00F, 4'd4, 0, 50, ok);
      wait_drain();
      if (!ok || got0.size() != 2 || bit_cnt0 !== 5'(mq0.size())) begin
         fails++; $display("FAIL bp_resume: got %0d bytes cnt %0d expected 2 bytes cnt %0d", got0.size(), bit_cnt0, mq0.size());
      end

      reset_dut();
      byte_ready = 1'b0;
      send_code(10'h07F, 4'd7, 0, 50, ok);
      send_code(10'h0AA, 4'd8, 0, 50, ok);
      tests += 4;
      if (!ok || cnt_at_load !== 5'd15) begin fails++; $display("FAIL bp15_peak1: got %0d expected 15", cnt_at_load); end
      send_code(10'h00F, 4'd8, 0, 50, ok);
      if (!ok || cnt_at_load !== 5'd15) begin fails++; $display("FAIL bp15_peak2: got %0d expected 15", cnt_at_load); end
      send_code(10'h3C3, 4'd10, 0, 30, ok);
      if (ok || bit_cnt0 !== 5'd15 || byte_valid0 !== 1'b1) begin
         fails++; $display("FAIL bp15_stall: got cap %b cnt %0d valid %b expected 0 15 1", ok, bit_cnt0, byte_valid0);
      end
      byte_ready = 1'b1;
      send_code(10'h3C3, 4'd10, 0, 50, ok);
      wait_drain();
      if (!ok || got0.size() != 4) begin fails++; $display("FAIL bp15_drain: got %0d bytes expected 4", got0.size()); end
   endtask

   task automatic test_flush();
      bit ok;
      reset_dut();
      byte_ready = 1'b1;
      send_code(10'h003, 4'd3, 0, 50, ok);
      flush = 1'b1; tick(); flush = 1'b0;
      model_flush();
      wait_flush();
      tests += 4;
      if (got0.size() != 1 || got0[0] !== 8'h60) begin fails++; $display("FAIL flush_pad0: got %p expected 60", got0); end
      if (got1.size() != 1 || got1[0] !== 8'h7F) begin fails++; $display("FAIL flush_pad1: got %p expected 7F", got1); end
      if (bit_cnt0 !== 5'd0 || byte_valid0 !== 1'b0) begin fails++; $display("FAIL flush_empty_after: got cnt %0d valid %b expected 0 0", bit_cnt0, byte_valid0); end
      if (fd_cnt != fd_exp) begin fails++; $display("FAIL flush_pulses: got %0d expected %0d", fd_cnt, fd_exp); end

      // Flushing an empty packer: done one cycle after the request, no byte.
      flush = 1'b1; tick(); flush = 1'b0;
      tests += 2;
      if (flush_done0 !== 1'b0) begin fails++; $display("FAIL flush0_early: got %b expected 0", flush_done0); end
      tick();
      if (flush_done0 !== 1'b1 || byte_valid0 !== 1'b0) begin fails++; $display("FAIL flush0_done: got %b/%b expected 1/0", flush_done0, byte_valid0); end
      model_flush();
      tick(2);

      // Flush raised while the code is still being acknowledged.
      got0.delete(); got1.delete();
      code_in = 10'h02D; code_len = 4'd6; code_valid = 1'b1; ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin tick(); ok = load0; end
      model_push(10'h02D, 4'd6);
      flush = 1'b1; tick(); flush = 1'b0; tick();
      code_valid = 1'b0;
      model_flush();
      wait_flush();
      tests += 2;
      if (!ok || got0.size() != 1 || got0[0] !== 8'hB4) begin fails++; $display("FAIL flush_ack0: got %p expected B4", got0); end
      if (got1.size() != 1 || got1[0] !== 8'hB7 || fd_cnt != fd_exp) begin
         fails++; $display("FAIL flush_ack1: got %p pulses %0d expected B7 pulses %0d", got1, fd_cnt, fd_exp);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      reset_dut();
      byte_ready = 1'b1;
      send_code(10'h0AB, 4'd8, 0, 50, ok);
      wait_drain();
      byte_ready = 1'b0;
      send_code(10'h0CD, 4'd8, 0, 50, ok);
      tick(2);
      code_in = 10'h01F; code_len = 4'd5; code_valid = 1'b1; ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin tick(); ok = load0; end
      tests += 7;
      if (!ok || byte_valid0 !== 1'b1 || byte_count0 !== 16'd1) begin
         fails++; $display("FAIL rmid_pre: got load %b valid %b count %0d expected 1 1 1", ok, byte_valid0, byte_count0);
      end
      reset = 1'b1; #1;
      if (load0 !== 1'b0) begin fails++; $display("FAIL rmid_load: got %b expected 0", load0); end
      if (byte_valid0 !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b expected 0", byte_valid0); end
      if (bit_cnt0 !== 5'd0) begin fails++; $display("FAIL rmid_bit_cnt: got %0d expected 0", bit_cnt0); end
      if (byte_count0 !== 16'd0) begin fails++; $display("FAIL rmid_count: got %0d expected 0", byte_count0); end
      if (byte_out0 !== 8'h00) begin fails++; $display("FAIL rmid_byte_out: got %h expected 00", byte_out0); end
      if (flush_done0 !== 1'b0) begin fails++; $display("FAIL rmid_flush_done: got %b expected 0", flush_done0); end
      model_clear();
      code_valid = 1'b0;
      tick();
      reset = 1'b0;
      byte_ready = 1'b1;
      send_code(10'h001, 4'd1, 0, 50, ok);
      send_code(10'h000, 4'd7, 0, 50, ok);
      wait_drain();
      tests += 2;
      if (got0.size() != 1 || got0[0] !== 8'h80) begin fails++; $display("FAIL rmid_repack: got %p expected 80", got0); end
      if (byte_count0 !== 16'd1) begin fails++; $display("FAIL rmid_recount: got %0d expected 1", byte_count0); end
   endtask

   task automatic test_random();
      bit ok;
      int codes = 0, lost = 0;
      reset_dut();
      rnd_on = 1'b1;
      fork
         while (rnd_on) begin @(posedge clk); #1; byte_ready = ($urandom_range(0, 3) != 0); end
      join_none
      for (int i = 0; i < 80; i++) begin
         send_code(10'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3), 400, ok);
         if (ok) codes++; else begin lost++; code_valid = 1'b0; tick(); end
         if ($urandom_range(0, 7) == 0) begin
            flush = 1'b1; tick(); flush = 1'b0;
            model_flush();
            wait_flush();
         end
      end
      rnd_on = 1'b0;
      tick(2);
      byte_ready = 1'b1;
      wait_drain();
      tests += 6;
      if (lost != 0) begin fails++; $display("FAIL rnd_capture: got %0d timeouts expected 0", lost); end
      if (eq0.size() != 0 || eq1.size() != 0) begin fails++; $display("FAIL rnd_leftover: got %0d/%0d expected 0", eq0.size(), eq1.size()); end
      if (byte_count0 !== 16'(nbytes)) begin fails++; $display("FAIL rnd_count: got %0d expected %0d", byte_count0, nbytes); end
      if (byte_count1 !== 3'(nbytes)) begin fails++; $display("FAIL rnd_count_wrap: got %0d expected %0d", byte_count1, nbytes % 8); end
      if (load_cnt != codes || fd_cnt != fd_exp) begin
         fails++; $display("FAIL rnd_pulses: got load %0d done %0d expected %0d %0d", load_cnt, fd_cnt, codes, fd_exp);
      end
      if (bit_cnt0 !== 5'(mq0.size())) begin fails++; $display("FAIL rnd_bit_cnt: got %0d expected %0d", bit_cnt0, mq0.size()); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_two_codes();
      test_hold();
      test_seventeen();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
